// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arb_pkg : shared types for the single-port RAM arbiter  (Rev 1.0)
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_DONE  = 3'd4
  } arb_state_e;

  typedef enum logic {
    CLIENT_WR = 1'b0,
    CLIENT_RD = 1'b1
  } client_e;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_port_arbiter_if : client handshakes and RAM port of the arbiter  (Rev 1.0)
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side: answers the clients and drives the RAM
  modport master (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
    output wr_ack, rd_data, rd_ack, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_rdata,
    input  wr_ack, rd_data, rd_ack, ram_addr, ram_wdata, ram_we
  );
endinterface
`default_nettype wire

// File: rtl/ram_arb_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arb_rr : combinational 2-way round-robin picker  (Rev 1.0)
// ---------------------------------------------------------------------------
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic    wr_req,
  input  logic    rd_req,
  input  client_e last_served,
  output logic    grant_valid,
  output client_e grant_client
);

  always_comb begin
    grant_valid  = wr_req | rd_req;
    grant_client = CLIENT_WR;
    if (wr_req && rd_req) begin
      grant_client = (last_served == CLIENT_WR) ? CLIENT_RD : CLIENT_WR;
    end else if (rd_req) begin
      grant_client = CLIENT_RD;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_port_arbiter : shares one single-port sync RAM between writer and reader
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  ram_port_arbiter_if.master bus,
  output logic               busy,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count
);

  localparam int              LAT_W    = 3;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  arb_state_e        state_q, state_d;
  client_e           last_served_q, last_served_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic              grant_valid;
  client_e           grant_client;

  ram_arb_rr u_rr (
    .wr_req       (bus.wr_req),
    .rd_req       (bus.rd_req),
    .last_served  (last_served_q),
    .grant_valid  (grant_valid),
    .grant_client (grant_client)
  );

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_data_d     = rd_data_q;
    lat_d         = lat_q;
    wr_count_d    = wr_count_q;
    rd_count_d    = rd_count_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_served_d = grant_client;
          if (grant_client == CLIENT_WR) begin
            addr_d  = bus.wr_addr;
            wdata_d = bus.wr_data;
            state_d = WRITE;
          end else begin
            addr_d  = bus.rd_addr;
            state_d = RD_ISSUE;
          end
        end
      end
      WRITE: begin
        wr_count_d = wr_count_q + CNT_W'(1);
        state_d    = IDLE;
      end
      RD_ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // RAM output is valid on the final wait cycle
        if (lat_q == '0) begin
          rd_data_d = bus.ram_rdata;
          state_d   = RD_DONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RD_DONE: begin
        rd_count_d = rd_count_q + CNT_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_served_q <= CLIENT_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_data_q     <= '0;
      lat_q         <= '0;
      wr_count_q    <= '0;
      rd_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_data_q     <= rd_data_d;
      lat_q         <= lat_d;
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
    end
  end

  assign bus.ram_we    = (state_q == WRITE);
  assign bus.wr_ack    = (state_q == WRITE);
  assign bus.rd_ack    = (state_q == RD_DONE);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.rd_data   = rd_data_q;
  assign busy          = (state_q != IDLE);
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;

endmodule
`default_nettype wire
